// File: rtl/madd_seq_pkg.sv
// Shared constants, state type and op-decode helpers for the MADD/MSUB sequencer.
// Optional pipelined multiplier: MADD_SEQ_PIPE_MUL_EN (see madd_seq.sv).
package madd_seq_pkg;

  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_0111;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  localparam logic        NOSTOP   = 1'b0;
  localparam int unsigned STALL_EX = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } state_e;

  function automatic logic is_madd_op(input logic [7:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
           (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

  function automatic logic op_is_signed(input logic [7:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MSUB_OP);
  endfunction

  function automatic logic op_is_sub(input logic [7:0] op);
    return (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

endpackage

// File: rtl/madd_seq_if.sv
// EX-stage bundle between the pipeline and the MADD/MSUB sequencer.
interface madd_seq_if #(parameter int DW = 32);

  logic [5:0]    stall;
  logic [7:0]    aluop_i;
  logic [DW-1:0] reg1_i;
  logic [DW-1:0] reg2_i;
  logic [DW-1:0] hi_i;
  logic [DW-1:0] lo_i;
  logic          stallreq_o;
  logic          whilo_o;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
  logic          busy_o;

  modport master (
    output stall, aluop_i, reg1_i, reg2_i, hi_i, lo_i,
    input  stallreq_o, whilo_o, hi_o, lo_o, busy_o
  );

  modport slave (
    input  stall, aluop_i, reg1_i, reg2_i, hi_i, lo_i,
    output stallreq_o, whilo_o, hi_o, lo_o, busy_o
  );

endinterface

// File: rtl/madd_seq_mul_sgn.sv
// DW x DW multiplier, signed/unsigned select, 2*DW product.
// MADD_SEQ_PIPE_MUL_EN adds an output register loaded when en is high.
module madd_seq_mul_sgn #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            sgn,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] p
);

  logic [2*DW-1:0] a_ext;
  logic [2*DW-1:0] b_ext;
  logic [2*DW-1:0] prod;

  // Extending to 2*DW first makes one unsigned multiplier exact for both modes.
  always_comb begin
    a_ext = sgn ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
    b_ext = sgn ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
    prod  = a_ext * b_ext;
  end

`ifdef MADD_SEQ_PIPE_MUL_EN
  logic [2*DW-1:0] p_q;
  logic [2*DW-1:0] p_d;

  always_comb p_d = en ? prod : p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end

  assign p = p_q;
`else
  logic unused_seq;
  assign unused_seq = ^{clk, rst, en};
  assign p = prod;
`endif

endmodule

// File: rtl/madd_seq.sv
// MADD/MADDU/MSUB/MSUBU sequencer: multiply phase then accumulate phase with one HI/LO write.
// MADD_SEQ_PIPE_MUL_EN enables the MUL state and a registered multiplier (3-cycle latency).
module madd_seq
  import madd_seq_pkg::*;
#(
  parameter int DW = 32
) (
  input logic       clk,
  input logic       rst,
  madd_seq_if.slave bus
);

  state_e          state_q, state_d;
  logic [2*DW-1:0] hilo_temp_q, hilo_temp_d;
  logic [2*DW-1:0] mul_p;
  logic [2*DW-1:0] acc_sum;
  logic            mul_en;
  logic            stallreq;
  logic            whilo;
  logic            ex_go;
  logic            issue;
  logic [DW-1:0]   hi_res;
  logic [DW-1:0]   lo_res;
  logic            unused_stall;

  assign ex_go        = (bus.stall[STALL_EX] == NOSTOP);
  assign issue        = !rst && is_madd_op(bus.aluop_i) && ex_go;
  assign acc_sum      = hilo_temp_q + {bus.hi_i, bus.lo_i};
  assign unused_stall = ^{bus.stall[5:4], bus.stall[2:0]};

  madd_seq_mul_sgn #(.DW(DW)) u_mul (
    .clk (clk),
    .rst (rst),
    .en  (mul_en),
    .sgn (op_is_signed(bus.aluop_i)),
    .a   (bus.reg1_i),
    .b   (bus.reg2_i),
    .p   (mul_p)
  );

`ifdef MADD_SEQ_PIPE_MUL_EN
  logic op_sub_q, op_sub_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_sub_q <= 1'b0;
    else     op_sub_q <= op_sub_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    hilo_temp_d = hilo_temp_q;
    mul_en      = 1'b0;
    stallreq    = 1'b0;
    whilo       = 1'b0;
    hi_res      = '0;
    lo_res      = '0;
`ifdef MADD_SEQ_PIPE_MUL_EN
    op_sub_d    = op_sub_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          stallreq = 1'b1;
          mul_en   = 1'b1;
`ifdef MADD_SEQ_PIPE_MUL_EN
          op_sub_d = op_is_sub(bus.aluop_i);
          state_d  = ST_MUL;
`else
          hilo_temp_d = op_is_sub(bus.aluop_i) ? -mul_p : mul_p;
          state_d     = ST_ACC;
`endif
        end
      end
      ST_MUL: begin
`ifdef MADD_SEQ_PIPE_MUL_EN
        stallreq = 1'b1;
        if (ex_go) begin
          hilo_temp_d = op_sub_q ? -mul_p : mul_p;
          state_d     = ST_ACC;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_ACC: begin
        // HI/LO are read here rather than at issue so MTHI/MTLO forwards land.
        {hi_res, lo_res} = acc_sum;
        whilo            = 1'b1;
        if (ex_go) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hilo_temp_q <= '0;
    end else begin
      state_q     <= state_d;
      hilo_temp_q <= hilo_temp_d;
    end
  end

  assign bus.stallreq_o = stallreq;
  assign bus.whilo_o    = whilo;
  assign bus.hi_o       = hi_res;
  assign bus.lo_o       = lo_res;
  assign bus.busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_madd_seq.sv
// Scoreboard bench for madd_seq; follows MADD_SEQ_PIPE_MUL_EN for the extra MUL cycle.
module tb_madd_seq;
  import madd_seq_pkg::*;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  madd_seq_if #(.DW(DW)) bus ();

  madd_seq #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == EXE_MADD_OP || op == EXE_MSUB_OP) p = 64'(sa * sb);
    else                                        p = {32'd0, a} * {32'd0, b};
    if (op == EXE_MSUB_OP || op == EXE_MSUBU_OP) p = 64'd0 - p;
    return p + {hi, lo};
  endfunction

  // Negedge sample; compares every cycle whilo_o is up, retires the entry when EX moves on.
  task automatic sample();
    @(negedge clk);
    if (bus.whilo_o) begin
      if (exp_q.size() == 0) begin
        chk("whilo_unexpected", 64'(bus.whilo_o), 0);
      end else begin
        chk("hilo_result", {bus.hi_o, bus.lo_o}, exp_q[0]);
        if (bus.stall[3] == 1'b0) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo,
                       input logic [63:0] exp, input int n_hold = 0);
    bus.aluop_i = op;
    bus.reg1_i  = a;
    bus.reg2_i  = b;
    bus.hi_i    = ~hi;
    bus.lo_i    = ~lo;
    bus.stall   = 6'b000000;
    exp_q.push_back(exp);
    sample();
    chk("stallreq_issue", 64'(bus.stallreq_o), 1);
    chk("whilo_issue", 64'(bus.whilo_o), 0);
    tick();
    bus.aluop_i = EXE_MSUB_OP;
    bus.reg1_i  = $urandom;
    bus.reg2_i  = $urandom;
    bus.hi_i    = hi;
    bus.lo_i    = lo;
    bus.aluop_i = 8'h00;
`ifdef MADD_SEQ_PIPE_MUL_EN
    sample();
    chk("stallreq_mul", 64'(bus.stallreq_o), 1);
    chk("whilo_mul", 64'(bus.whilo_o), 0);
    tick();
`endif
    for (int i = 0; i < n_hold; i++) begin
      bus.stall = 6'b011111;
      sample();
      chk("whilo_hold", 64'(bus.whilo_o), 1);
      chk("stallreq_hold", 64'(bus.stallreq_o), 0);
      tick();
    end
    bus.stall = 6'b000000;
    sample();
    chk("stallreq_acc", 64'(bus.stallreq_o), 0);
    chk("busy_acc", 64'(bus.busy_o), 1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  ops [4];
    logic [7:0]  op;
    logic [31:0] a, b, hi, lo;

    ops[0] = EXE_MADD_OP;
    ops[1] = EXE_MADDU_OP;
    ops[2] = EXE_MSUB_OP;
    ops[3] = EXE_MSUBU_OP;

    bus.stall   = 6'b000000;
    bus.aluop_i = EXE_MADD_OP;
    bus.reg1_i  = 32'd3;
    bus.reg2_i  = 32'd4;
    bus.hi_i    = 32'd1;
    bus.lo_i    = 32'd1;

    #12;
    chk("rst_stallreq", 64'(bus.stallreq_o), 0);
    chk("rst_whilo", 64'(bus.whilo_o), 0);
    chk("rst_hilo", {bus.hi_o, bus.lo_o}, 0);
    chk("rst_busy", 64'(bus.busy_o), 0);
    @(negedge clk);
    bus.aluop_i = 8'h00;
    rst = 1'b0;
    tick();

    issue(EXE_MADD_OP,  32'd3,        32'hFFFF_FFFE, 32'd0, 32'd5,   64'hFFFF_FFFF_FFFF_FFFF);
    issue(EXE_MADDU_OP, 32'hFFFF_FFFF, 32'd2,        32'd0, 32'd0,   64'h0000_0001_FFFF_FFFE);
    issue(EXE_MSUB_OP,  32'd2,        32'd3,         32'd0, 32'd10,  64'd4);
    issue(EXE_MSUBU_OP, 32'd5,        32'd7,         32'd0, 32'd100, 64'd65);
    issue(EXE_MADD_OP,  32'd7,        32'd6,         32'd1, 32'd2,   64'h0000_0001_0000_002C, 3);

    sample();
    chk("idle_after_hold_busy", 64'(bus.busy_o), 0);
    chk("idle_after_hold_whilo", 64'(bus.whilo_o), 0);
    tick();

    // EX held at issue: op must not be taken
    bus.aluop_i = EXE_MADD_OP;
    bus.stall   = 6'b001000;
    sample();
    chk("stalled_issue_stallreq", 64'(bus.stallreq_o), 0);
    tick();
    bus.aluop_i = 8'h00;
    bus.stall   = 6'b000000;
    sample();
    chk("stalled_issue_busy", 64'(bus.busy_o), 0);
    tick();

    for (int n = 0; n < 8; n++) begin
      op = ops[$urandom_range(0, 3)];
      a  = $urandom;
      b  = $urandom;
      hi = $urandom;
      lo = $urandom;
      issue(op, a, b, hi, lo, model(op, a, b, hi, lo));
    end

    // Abort in ACC with reset
    bus.aluop_i = EXE_MADD_OP;
    bus.reg1_i  = 32'd9;
    bus.reg2_i  = 32'd9;
    bus.stall   = 6'b000000;
    exp_q.push_back(64'd86);
    sample();
    tick();
    bus.aluop_i = 8'h00;
    bus.hi_i    = 32'd0;
    bus.lo_i    = 32'd5;
    bus.stall   = 6'b001000;
`ifdef MADD_SEQ_PIPE_MUL_EN
    bus.stall   = 6'b000000;
    sample();
    tick();
    bus.stall   = 6'b001000;
`endif
    sample();
    #1 rst = 1'b1;
    #1;
    chk("abort_whilo", 64'(bus.whilo_o), 0);
    chk("abort_hilo", {bus.hi_o, bus.lo_o}, 0);
    chk("abort_busy", 64'(bus.busy_o), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.stall = 6'b000000;
    tick();

    issue(EXE_MADD_OP, 32'd3, 32'hFFFF_FFFE, 32'd0, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF);

    sample();
    chk("final_busy", 64'(bus.busy_o), 0);
    chk("queue_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
